iomem_uart_master: RTL and testbench

Debug bus initiator for the picosoc `iomem` port. It consumes a byte stream (typically from a UART receiver), decodes framed read and write commands, and drives single 32-bit `iomem` transactions against any `iomem` responder, such as the GPIO register at 0x03xx_xxxx. It returns a status byte or read data as a byte stream for a UART transmitter. It lets a host poke peripherals without firmware running on the core.

---
 rtl/iomem_uart_master_pkg.sv | 24 ++
 rtl/iomem_uart_master_resp.sv | 38 +++
 rtl/iomem_uart_master.sv | 182 ++++++++++++++++++
 tb/tb_iomem_uart_master.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/iomem_uart_master_pkg.sv
// rtl/iomem_uart_master_pkg.sv - command/response constants, FSM states and response length type
package iomem_uart_master_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_OK    = 8'h4B;
    localparam logic [7:0] RSP_ERR   = 8'h3F;
    localparam logic [7:0] RSP_TMO   = 8'h54;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_BUS,
        ST_RESP
    } state_t;

    // Number of response bytes still to send (0..4)
    typedef logic [2:0] resp_len_t;

    localparam resp_len_t LEN_BYTE = 3'd1;
    localparam resp_len_t LEN_WORD = 3'd4;

endpackage

// File: rtl/iomem_uart_master_resp.sv
// rtl/iomem_uart_master_resp.sv - 4-byte load-and-shift response serializer, MSB first
module iomem_uart_master_resp
    import iomem_uart_master_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic [31:0] load_data,
    input  resp_len_t   load_len,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        done
);

    logic [31:0] shreg;
    resp_len_t   count;

    // Load a new response, or shift out one byte per handshake
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shreg <= 32'h0;
            count <= '0;
        end else if (load) begin
            shreg <= load_data;
            count <= load_len;
        end else if (tx_valid && tx_ready) begin
            shreg <= {shreg[23:0], 8'h00};
            count <= count - resp_len_t'(1);
        end
    end

    assign tx_valid = (count != '0);
    assign tx_data  = shreg[31:24];
    // Single-byte responses are loaded into the top byte, so the top byte is always next
    assign done     = tx_valid && tx_ready && (count == resp_len_t'(1));

endmodule

// File: rtl/iomem_uart_master.sv
// rtl/iomem_uart_master.sv - byte-stream to iomem bus initiator (optional IOMEM_UART_MASTER_TIMEOUT_EN)
module iomem_uart_master
    import iomem_uart_master_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic [7:0]  rx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        iomem_valid,
    input  logic        iomem_ready,
    output logic [3:0]  iomem_wstrb,
    output logic [31:0] iomem_addr,
    output logic [31:0] iomem_wdata,
    input  logic [31:0] iomem_rdata,
    output logic        busy
);

    state_t      state, state_d;
    logic        cmd_write;
    logic [1:0]  byte_cnt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        rx_ready_c;
    logic        latch_cmd;
    logic        addr_shift;
    logic        data_shift;
    logic        resp_load;
    logic [31:0] resp_data;
    resp_len_t   resp_len;
    logic        resp_done;
    logic        tmo_expired;

`ifdef IOMEM_UART_MASTER_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] tmo_cnt;

    // Count BUS cycles; cleared whenever the FSM is elsewhere
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tmo_cnt <= 16'h0;
        end else if (state == ST_BUS) begin
            tmo_cnt <= tmo_cnt + 16'h1;
        end else begin
            tmo_cnt <= 16'h0;
        end
    end

    // Expires on the last allowed valid cycle; ready in that same cycle still wins
    assign tmo_expired = (tmo_cnt == TMO_LAST);
`else
    assign tmo_expired = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Frame capture: command type, byte counter, address and data shift registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cmd_write <= 1'b0;
            byte_cnt  <= 2'd0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
        end else begin
            if (latch_cmd) begin
                cmd_write <= (rx_data == CMD_WRITE);
                byte_cnt  <= 2'd0;
            end else if (addr_shift || data_shift) begin
                byte_cnt  <= byte_cnt + 2'd1;
            end
            if (addr_shift) begin
                addr_q  <= {addr_q[23:0], rx_data};
            end
            if (data_shift) begin
                wdata_q <= {wdata_q[23:0], rx_data};
            end
        end
    end

    // Next-state and per-state outputs
    always_comb begin
        state_d     = state;
        rx_ready_c  = 1'b0;
        iomem_valid = 1'b0;
        latch_cmd   = 1'b0;
        addr_shift  = 1'b0;
        data_shift  = 1'b0;
        resp_load   = 1'b0;
        resp_data   = 32'h0;
        resp_len    = LEN_BYTE;
        case (state)
            ST_IDLE: begin
                rx_ready_c = 1'b1;
                if (rx_valid) begin
                    if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
                        latch_cmd = 1'b1;
                        state_d   = ST_ADDR;
                    end else begin
                        resp_load = 1'b1;
                        resp_data = {RSP_ERR, 24'h0};
                        state_d   = ST_RESP;
                    end
                end
            end
            ST_ADDR: begin
                rx_ready_c = 1'b1;
                if (rx_valid) begin
                    addr_shift = 1'b1;
                    if (byte_cnt == 2'd3) begin
                        state_d = cmd_write ? ST_DATA : ST_BUS;
                    end
                end
            end
            ST_DATA: begin
                rx_ready_c = 1'b1;
                if (rx_valid) begin
                    data_shift = 1'b1;
                    if (byte_cnt == 2'd3) begin
                        state_d = ST_BUS;
                    end
                end
            end
            ST_BUS: begin
                iomem_valid = 1'b1;
                if (iomem_ready) begin
                    resp_load = 1'b1;
                    if (cmd_write) begin
                        resp_data = {RSP_OK, 24'h0};
                        resp_len  = LEN_BYTE;
                    end else begin
                        resp_data = iomem_rdata;
                        resp_len  = LEN_WORD;
                    end
                    state_d = ST_RESP;
                end else if (tmo_expired) begin
                    resp_load = 1'b1;
                    resp_data = {RSP_TMO, 24'h0};
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Held low while reset is asserted even though the FSM already sits in IDLE
    assign rx_ready    = rx_ready_c & resetn;
    assign iomem_wstrb = (state == ST_BUS && cmd_write) ? 4'hF : 4'h0;
    assign iomem_addr  = addr_q;
    assign iomem_wdata = wdata_q;
    assign busy        = (state != ST_IDLE);

    iomem_uart_master_resp u_resp (
        .clk       (clk),
        .resetn    (resetn),
        .load      (resp_load),
        .load_data (resp_data),
        .load_len  (resp_len),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .done      (resp_done)
    );

endmodule

// File: tb/tb_iomem_uart_master.sv
// tb/tb_iomem_uart_master.sv - directed self-checking bench for iomem_uart_master
`timescale 1ns/1ps
module tb_iomem_uart_master;

    logic        clk;
    logic        resetn;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    iomem_uart_master #(.TIMEOUT(8)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check_eq("rx_ready_timeout", 32'(rx_ready), 32'h1);
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] addr,
                              input logic [31:0] data, input bit with_data);
        send_byte(cmd);
        for (int i = 3; i >= 0; i--) send_byte(addr[i*8 +: 8]);
        if (with_data) for (int i = 3; i >= 0; i--) send_byte(data[i*8 +: 8]);
    endtask

    // Responder: ready asserted on valid cycle waits+1; returns valid-high cycle count
    task automatic do_bus(input int waits, input logic [31:0] rd, output int vcycles);
        vcycles = 0;
        for (int i = 0; i < waits; i++) begin
            if (iomem_valid) vcycles++;
            tick();
        end
        if (iomem_valid) vcycles++;
        iomem_ready = 1'b1;
        iomem_rdata = rd;
        tick();
        iomem_ready = 1'b0;
        iomem_rdata = 32'h0;
        check_eq("valid_drop_after_ready", 32'(iomem_valid), 32'h0);
    endtask

    task automatic recv_byte(input string tag, input logic [7:0] exp);
        int n;
        n = 0;
        while (!tx_valid && n < 50) begin
            tick();
            n++;
        end
        check_eq({tag, "_valid"}, 32'(tx_valid), 32'h1);
        check_eq(tag, 32'(tx_data), 32'(exp));
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_rx_ready"}, 32'(rx_ready), 32'h0);
        check_eq({tag, "_tx_valid"}, 32'(tx_valid), 32'h0);
        check_eq({tag, "_tx_data"}, 32'(tx_data), 32'h0);
        check_eq({tag, "_iomem_valid"}, 32'(iomem_valid), 32'h0);
        check_eq({tag, "_wstrb"}, 32'(iomem_wstrb), 32'h0);
        check_eq({tag, "_addr"}, iomem_addr, 32'h0);
        check_eq({tag, "_wdata"}, iomem_wdata, 32'h0);
        check_eq({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int vc;
        int bad;
        logic [7:0] first;

        resetn      = 1'b0;
        rx_valid    = 1'b0;
        rx_data     = 8'h00;
        tx_ready    = 1'b0;
        iomem_ready = 1'b0;
        iomem_rdata = 32'h0;
        repeat (3) tick();
        check_reset_outputs("rst");
        resetn = 1'b1;
        #1;
        check_eq("rx_ready_after_release", 32'(rx_ready), 32'h1);
        tick();

        // Write, ready on first valid cycle
        send_frame(8'h57, 32'h0300_0000, 32'h0000_00A5, 1'b1);
        check_eq("wr_valid", 32'(iomem_valid), 32'h1);
        check_eq("wr_addr", iomem_addr, 32'h0300_0000);
        check_eq("wr_wdata", iomem_wdata, 32'h0000_00A5);
        check_eq("wr_wstrb", 32'(iomem_wstrb), 32'hF);
        check_eq("wr_rx_ready_bus", 32'(rx_ready), 32'h0);
        do_bus(0, 32'h0, vc);
        check_eq("wr_valid_cycles", 32'(vc), 32'd1);
        recv_byte("wr_resp", 8'h4B);
        check_eq("wr_busy_end", 32'(busy), 32'h0);

        // Read, 3 wait cycles, full-rate response
        send_frame(8'h52, 32'h0300_0000, 32'h0, 1'b0);
        check_eq("rd_valid", 32'(iomem_valid), 32'h1);
        check_eq("rd_wstrb", 32'(iomem_wstrb), 32'h0);
        do_bus(3, 32'hDEAD_BEEF, vc);
        check_eq("rd_valid_cycles", 32'(vc), 32'd4);
        recv_byte("rd_b0", 8'hDE);
        recv_byte("rd_b1", 8'hAD);
        recv_byte("rd_b2", 8'hBE);
        recv_byte("rd_b3", 8'hEF);
        check_eq("rd_busy_end", 32'(busy), 32'h0);

        // Unknown command, then a read still works
        send_byte(8'h00);
        recv_byte("unk_resp", 8'h3F);
        check_eq("unk_busy_end", 32'(busy), 32'h0);
        send_frame(8'h52, 32'h0300_0010, 32'h0, 1'b0);
        check_eq("unk_rd_addr", iomem_addr, 32'h0300_0010);
        do_bus(1, 32'h0102_0304, vc);
        recv_byte("unk_rd_b0", 8'h01);
        recv_byte("unk_rd_b1", 8'h02);
        recv_byte("unk_rd_b2", 8'h03);
        recv_byte("unk_rd_b3", 8'h04);

        // Stalled response: tx_data stable, input back-pressured
        send_frame(8'h52, 32'h0300_0020, 32'h0, 1'b0);
        do_bus(0, 32'hCAFE_F00D, vc);
        check_eq("stall_tx_valid", 32'(tx_valid), 32'h1);
        first    = tx_data;
        rx_valid = 1'b1;
        rx_data  = 8'h52;
        bad      = 0;
        for (int i = 0; i < 10; i++) begin
            if (tx_data !== first || tx_valid !== 1'b1 || rx_ready !== 1'b0) bad++;
            tick();
        end
        rx_valid = 1'b0;
        check_eq("stall_violations", 32'(bad), 32'd0);
        recv_byte("stall_b0", 8'hCA);
        recv_byte("stall_b1", 8'hFE);
        recv_byte("stall_b2", 8'hF0);
        recv_byte("stall_b3", 8'h0D);

`ifdef IOMEM_UART_MASTER_TIMEOUT_EN
        // Responder never ready: exactly TIMEOUT valid cycles then 'T'
        send_frame(8'h52, 32'h0300_0030, 32'h0, 1'b0);
        vc = 0;
        while (iomem_valid && vc < 40) begin
            vc++;
            tick();
        end
        check_eq("tmo_valid_cycles", 32'(vc), 32'd8);
        recv_byte("tmo_resp", 8'h54);
        // Ready on the final allowed cycle wins
        send_frame(8'h52, 32'h0300_0030, 32'h0, 1'b0);
        do_bus(7, 32'h0BAD_F00D, vc);
        check_eq("tmo_edge_cycles", 32'(vc), 32'd8);
        recv_byte("tmo_edge_b0", 8'h0B);
        recv_byte("tmo_edge_b1", 8'hAD);
        recv_byte("tmo_edge_b2", 8'hF0);
        recv_byte("tmo_edge_b3", 8'h0D);
`endif

        // Reset mid-frame after three address bytes
        send_byte(8'h57);
        send_byte(8'h03);
        send_byte(8'h00);
        send_byte(8'h00);
        check_eq("mid_busy", 32'(busy), 32'h1);
        resetn = 1'b0;
        #1;
        check_reset_outputs("midrst");
        tick();
        resetn = 1'b1;
        tick();
        send_frame(8'h57, 32'h0300_0004, 32'h1234_5678, 1'b1);
        check_eq("post_addr", iomem_addr, 32'h0300_0004);
        check_eq("post_wdata", iomem_wdata, 32'h1234_5678);
        check_eq("post_wstrb", 32'(iomem_wstrb), 32'hF);
        do_bus(2, 32'h0, vc);
        check_eq("post_valid_cycles", 32'(vc), 32'd3);
        recv_byte("post_resp", 8'h4B);
        check_eq("post_busy_end", 32'(busy), 32'h0);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
